// File: rtl/xpb_acc_pkg.sv
// Shared types and constants for the xpb term accumulator.
// Provides the FSM state encoding, the xpb word width and the sum-width helper.
package xpb_acc_pkg;

  localparam int XPB_WORD_BITS = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } xpb_acc_state_e;

  // Width that holds (n+1) words of w bits without overflow.
  function automatic int xpb_sum_bits(input int w, input int n);
    return w + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xpb_acc_adder.sv
// Parameterised ripple-free carry-propagate adder with carry-in and carry-out.
// Ports: a_i, b_i, cin_i -> sum_o, cout_o (all W bits wide except the carries).
module xpb_acc_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i}
                         + {1'b0, b_i}
                         + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/xpb_term_accumulator.sv
// Serially sums a base word plus NUM_TERMS xpb residues, one term per step,
// and hands the sum downstream over valid/ready.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_base/in_terms,
//        out_valid/out_ready/out_sum, busy.
// XPB_ACC_SPLIT_ADD_EN: split each add into low/high halves over two cycles.
module xpb_term_accumulator
  import xpb_acc_pkg::*;
#(
  parameter int WORD_BITS = XPB_WORD_BITS,
  parameter int NUM_TERMS = 8,
  parameter int SUM_BITS  = xpb_sum_bits(WORD_BITS, NUM_TERMS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_BITS-1:0]           in_base,
  input  logic [NUM_TERMS*WORD_BITS-1:0] in_terms,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SUM_BITS-1:0]            out_sum,
  output logic                           busy
);

  localparam int IDX_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TERMS - 1);

  xpb_acc_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_BITS-1:0] acc_q, acc_d;
  logic [NUM_TERMS*WORD_BITS-1:0] terms_q;
  logic accept;

  logic [WORD_BITS-1:0] term_sel;
  logic [SUM_BITS-1:0]  term_ext;
  logic [SUM_BITS-1:0]  acc_step;
  logic                 step_done;
  logic                 unused_cout;

  always_comb begin
    term_sel = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        term_sel = terms_q[i*WORD_BITS +: WORD_BITS];
      end
    end
  end

  assign term_ext = SUM_BITS'(term_sel);

`ifdef XPB_ACC_SPLIT_ADD_EN
  localparam int LO_W = (SUM_BITS + 1) / 2;
  localparam int HI_W = SUM_BITS - LO_W;

  logic            phase_q, phase_d;
  logic            carry_q, carry_d;
  logic [LO_W-1:0] lo_sum;
  logic            lo_cout;
  logic [HI_W-1:0] hi_sum;

  xpb_acc_adder #(.W(LO_W)) u_add_lo (
    .a_i    (acc_q[LO_W-1:0]),
    .b_i    (term_ext[LO_W-1:0]),
    .cin_i  (1'b0),
    .sum_o  (lo_sum),
    .cout_o (lo_cout)
  );

  xpb_acc_adder #(.W(HI_W)) u_add_hi (
    .a_i    (acc_q[SUM_BITS-1:LO_W]),
    .b_i    (term_ext[SUM_BITS-1:LO_W]),
    .cin_i  (carry_q),
    .sum_o  (hi_sum),
    .cout_o (unused_cout)
  );

  // Phase 0 adds the low half and parks its carry;
  // phase 1 folds that carry into the high half.
  always_comb begin
    phase_d = 1'b0;
    carry_d = 1'b0;
    if (state_q == ACCUM) begin
      phase_d = ~phase_q;
      carry_d = phase_q ? 1'b0 : lo_cout;
    end
  end

  assign acc_step = phase_q
    ? {hi_sum, acc_q[LO_W-1:0]}
    : {acc_q[SUM_BITS-1:LO_W], lo_sum};
  assign step_done = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      carry_q <= carry_d;
    end
  end
`else
  xpb_acc_adder #(.W(SUM_BITS)) u_add (
    .a_i    (acc_q),
    .b_i    (term_ext),
    .cin_i  (1'b0),
    .sum_o  (acc_step),
    .cout_o (unused_cout)
  );

  assign step_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          acc_d   = SUM_BITS'(in_base);
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_step;
        if (step_done) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terms_q <= '0;
    end else if (accept) begin
      terms_q <= in_terms;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;

endmodule

// File: tb/tb_xpb_term_accumulator.sv
// Scoreboard bench for xpb_term_accumulator: directed and random sums,
// backpressure, reset mid-transaction, latency and overflow width.
module tb_xpb_term_accumulator;

  localparam int W  = 1024;
  localparam int NT = 8;
  localparam int SB = W + $clog2(NT + 1);
`ifdef XPB_ACC_SPLIT_ADD_EN
  localparam int LAT = 2 * NT;
`else
  localparam int LAT = NT;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_base;
  logic [NT*W-1:0] in_terms;
  logic            out_valid;
  logic            out_ready;
  logic [SB-1:0]   out_sum;
  logic            busy;

  logic [SB-1:0] sbq[$];
  int checks;
  int errors;
  logic rdy_rand;
  logic rdy_force;

  xpb_term_accumulator #(
    .WORD_BITS (W),
    .NUM_TERMS (NT),
    .SUM_BITS  (SB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_terms  (in_terms),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [SB-1:0] act,
                     input logic [SB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h..%h expected %h..%h", nm,
               act[SB-1:SB-16], act[63:0], exp[SB-1:SB-16], exp[63:0]);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rword();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NT*W-1:0] rterms();
    logic [NT*W-1:0] t;
    for (int i = 0; i < NT; i++) t[i*W +: W] = rword();
    return t;
  endfunction

  // out_ready driver: random or forced level, updated just after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom) : rdy_force;
    end
  end

  // Monitor: every output handshake pops one expected sum.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected no output",
                   out_sum[63:0]);
        end else begin
          chk("out_sum", out_sum, sbq.pop_front());
        end
      end
    end
  end

  // Returns #1 after the accepting edge; inputs are scrambled afterwards.
  task automatic send(input logic [W-1:0] b, input logic [NT*W-1:0] t,
                      input bit push);
    logic [SB-1:0] e;
    int n;
    in_base  = b;
    in_terms = t;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
    end else if (push) begin
      e = SB'(b);
      for (int i = 0; i < NT; i++) e = e + SB'(t[i*W +: W]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_base  = rword();
    in_terms = rterms();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NT*W-1:0] t;
    logic [SB-1:0]   cap;
    logic [W-1:0]    ones;
    int n;
    int bad;
    checks    = 0;
    errors    = 0;
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_base   = '0;
    in_terms  = '0;
    ones      = '1;

    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      in_base  = rword();
      in_terms = rterms();
    end
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_out_valid", out_valid, 1'b0);

    // Basic: base 5 plus terms 1..8 = 41.
    rdy_force = 1'b1;
    for (int i = 0; i < NT; i++) t[i*W +: W] = W'(i + 1);
    send(W'(5), t, 1'b1);
    bad = 0;
    n = 0;
    while (!out_valid && n < 200) begin
      if (!busy) bad = 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("basic_latency", SB'(n), SB'(LAT));
    chk("basic_busy", SB'(bad), '0);
    chk("basic_sum", out_sum, SB'(41));
    @(posedge clk);
    #1;
    chk1("basic_back_idle", in_ready, 1'b1);
    chk1("basic_valid_drop", out_valid, 1'b0);

    // Overflow width under backpressure.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NT; i++) t[i*W +: W] = ones;
    send(ones, t, 1'b1);
    wait_valid(n);
    chk("ovf_latency", SB'(n), SB'(LAT));
    chk("ovf_top_bits", SB'(out_sum[SB-1:W]), SB'(4'h8));
    cap = out_sum;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      in_base  = rword();
      in_terms = rterms();
      @(posedge clk);
      #1;
      if (!out_valid || out_sum !== cap || in_ready) bad++;
    end
    in_valid = 1'b0;
    chk("bp_stable", SB'(bad), '0);
    rdy_force = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #1;
    chk1("bp_release_idle", in_ready, 1'b1);
    chk1("bp_release_valid", out_valid, 1'b0);

    // Reset in the middle of ACCUM.
    send(W'(7), rterms(), 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", in_ready, 1'b1);
    chk("midrst_sum", out_sum, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) bad = 1;
    end
    chk("midrst_no_valid", SB'(bad), '0);
    for (int i = 0; i < NT; i++) t[i*W +: W] = W'(1);
    send('0, t, 1'b1);
    wait_valid(n);
    chk("after_rst_sum", out_sum, SB'(8));

    // Random back-to-back with random out_ready.
    rdy_rand = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      send(rword(), rterms(), 1'b1);
    end
    n = 0;
    while (sbq.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", SB'(sbq.size()), '0);
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
